pcoeff_sum_accumulator: RTL

- Downstream consumer of the streaming connected-count core's result stream (resultValid / connectCount / extraDataOut).
- Per valid result, forms the term 2^connectCount and accumulates terms into a running batch sum; a batch ends on the input flagged lastOfBatch.
- Completed batch sums are queued in a small output FIFO and drained with a valid/ready handshake.
- The input side cannot stall. The block raises slowDownInput early so the producer throttles before the queue overflows.

---
 rtl/pcoeff_sum_accumulator.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pcoeff_sum_accumulator.sv
// Batch accumulator of 2^connectCount terms feeding a show-ahead output queue.
// Define PCOEFF_TERM_COUNT_EN to add a per-batch termCount output.
module pcoeff_sum_accumulator #(
    parameter int unsigned SUM_WIDTH            = 48,
    parameter int unsigned OUT_FIFO_DEPTH_LOG2  = 3,
    parameter int unsigned OUT_FIFO_ALMOST_FULL = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 resultValid,
    input  logic [5:0]           connectCount,
    input  logic                 lastOfBatch,
    input  logic                 eccStatusIn,
    output logic                 slowDownInput,
    output logic                 sumValid,
    input  logic                 sumReady,
    output logic [SUM_WIDTH-1:0] sumOut,
    output logic                 sumOverflow,
    output logic                 eccStatus,
    output logic                 queueOverflow
`ifdef PCOEFF_TERM_COUNT_EN
    ,
    output logic [15:0]          termCount
`endif
);

    localparam int Depth = 1 << OUT_FIFO_DEPTH_LOG2;
    localparam int PtrW  = OUT_FIFO_DEPTH_LOG2 + 1;

    // S1 input register
    logic                 s1_valid_q, s1_last_q;
    logic [5:0]           s1_count_q;
    // S2 decoded term
    logic                 s2_valid_q, s2_last_q, s2_tovf_q;
    logic [SUM_WIDTH-1:0] s2_term_q, s2_term_d;
    logic                 s2_tovf_d;
    // S3 accumulator
    logic [SUM_WIDTH-1:0] acc_q, acc_d;
    logic                 bovf_q, bovf_d, bovf_next;
    logic [SUM_WIDTH:0]   acc_sum;
    // Closed-batch register feeding the queue write
    logic                 push_valid_q, push_valid_d;
    logic [SUM_WIDTH-1:0] push_sum_q, push_sum_d;
    logic                 push_ovf_q, push_ovf_d;
    // Queue
    logic [SUM_WIDTH-1:0] mem_sum_q [Depth];
    logic                 mem_ovf_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q, occ;
    logic [PtrW-2:0]      wr_idx, rd_idx;
    logic                 full, pop, push, drop;
    logic                 ecc_q, qovf_q, slow_q, slow_d;
`ifdef PCOEFF_TERM_COUNT_EN
    logic [15:0]          cnt_q, cnt_d, cnt_inc;
    logic [15:0]          push_cnt_q, push_cnt_d;
    logic [15:0]          mem_cnt_q [Depth];
`endif

    always_comb begin
        s2_term_d = '0;
        s2_tovf_d = 1'b0;
        if (32'(s1_count_q) < SUM_WIDTH) begin
            s2_term_d[s1_count_q] = 1'b1;
        end else begin
            s2_tovf_d = 1'b1;
        end
    end

    always_comb begin
        acc_sum      = {1'b0, acc_q} + {1'b0, s2_term_q};
        bovf_next    = bovf_q | acc_sum[SUM_WIDTH] | s2_tovf_q;
        acc_d        = acc_q;
        bovf_d       = bovf_q;
        push_valid_d = 1'b0;
        push_sum_d   = push_sum_q;
        push_ovf_d   = push_ovf_q;
`ifdef PCOEFF_TERM_COUNT_EN
        cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        cnt_d        = cnt_q;
        push_cnt_d   = push_cnt_q;
`endif
        if (s2_valid_q) begin
            if (s2_last_q) begin
                // Close the batch; the next valid term starts a fresh sum.
                acc_d        = '0;
                bovf_d       = 1'b0;
                push_valid_d = 1'b1;
                push_sum_d   = acc_sum[SUM_WIDTH-1:0];
                push_ovf_d   = bovf_next;
`ifdef PCOEFF_TERM_COUNT_EN
                cnt_d        = '0;
                push_cnt_d   = cnt_inc;
`endif
            end else begin
                acc_d  = acc_sum[SUM_WIDTH-1:0];
                bovf_d = bovf_next;
`ifdef PCOEFF_TERM_COUNT_EN
                cnt_d  = cnt_inc;
`endif
            end
        end
    end

    always_comb begin
        occ    = wr_ptr_q - rd_ptr_q;
        full   = occ[PtrW-1];
        wr_idx = wr_ptr_q[PtrW-2:0];
        rd_idx = rd_ptr_q[PtrW-2:0];
        pop    = sumValid && sumReady;
        push   = push_valid_q && (!full || pop);
        drop   = push_valid_q && full && !pop;
        slow_d = 32'(occ) > OUT_FIFO_ALMOST_FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_count_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_tovf_q    <= 1'b0;
            s2_term_q    <= '0;
            acc_q        <= '0;
            bovf_q       <= 1'b0;
            push_valid_q <= 1'b0;
            push_sum_q   <= '0;
            push_ovf_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ecc_q        <= 1'b0;
            qovf_q       <= 1'b0;
            slow_q       <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                mem_sum_q[i] <= '0;
                mem_ovf_q[i] <= 1'b0;
`ifdef PCOEFF_TERM_COUNT_EN
                mem_cnt_q[i] <= '0;
`endif
            end
`ifdef PCOEFF_TERM_COUNT_EN
            cnt_q      <= '0;
            push_cnt_q <= '0;
`endif
        end else begin
            s1_valid_q   <= resultValid;
            s1_last_q    <= lastOfBatch;
            s1_count_q   <= connectCount;
            s2_valid_q   <= s1_valid_q;
            s2_last_q    <= s1_last_q;
            s2_tovf_q    <= s2_tovf_d;
            s2_term_q    <= s2_term_d;
            acc_q        <= acc_d;
            bovf_q       <= bovf_d;
            push_valid_q <= push_valid_d;
            push_sum_q   <= push_sum_d;
            push_ovf_q   <= push_ovf_d;
            ecc_q        <= ecc_q | eccStatusIn;
            qovf_q       <= qovf_q | drop;
            slow_q       <= slow_d;
            if (push) begin
                mem_sum_q[wr_idx] <= push_sum_q;
                mem_ovf_q[wr_idx] <= push_ovf_q;
`ifdef PCOEFF_TERM_COUNT_EN
                mem_cnt_q[wr_idx] <= push_cnt_q;
`endif
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
`ifdef PCOEFF_TERM_COUNT_EN
            cnt_q      <= cnt_d;
            push_cnt_q <= push_cnt_d;
`endif
        end
    end

    assign sumValid      = (wr_ptr_q != rd_ptr_q);
    assign sumOut        = mem_sum_q[rd_idx];
    assign sumOverflow   = mem_ovf_q[rd_idx];
    assign eccStatus     = ecc_q;
    assign queueOverflow = qovf_q;
    assign slowDownInput = slow_q;
`ifdef PCOEFF_TERM_COUNT_EN
    assign termCount     = mem_cnt_q[rd_idx];
`endif

endmodule
